// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package kb_pkg;

  // Deframer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } kb_state_t;

  // Prefix bytes folded into event flags.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Decoded key event.
  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } kb_evt_t;

endpackage

// File: rtl/ps2_sync.sv
// PS/2 pin synchronisers with a falling-edge detector on the clock pin.
module ps2_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];

  // Synchroniser chains idle high like the bus; previous clock level for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data_i};
      r_clk_prev <= w_clk_s;
    end
  end

  assign data_s = r_dat_sync[SYNC_STAGES-1];
  assign fall   = r_clk_prev & ~w_clk_s;

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes, emits key events.
module ps2_kb_rx
  import kb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       release_o,
  output logic       extended_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       err_o,
  output logic       overrun_o
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic            w_data_s;
  logic            w_fall;
  kb_state_t       r_state;
  kb_state_t       w_state_nxt;
  logic            w_timeout;
  logic            w_stop_done;
  logic            w_good;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_par;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ext_flag;
  logic            r_brk_flag;
  logic            r_new_vld;
  kb_evt_t         r_new_evt;
  kb_evt_t         r_out_evt;
  logic            r_valid;
  logic            r_err;
  logic            r_overrun;

  ps2_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .data_s    (w_data_s),
    .fall      (w_fall)
  );

  // Deframer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state on PS/2 falling edges, with timeout abort of partial frames.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_stop_done = 1'b0;
    w_good      = (^{r_shift, r_par}) & w_data_s;
    case (r_state)
      ST_IDLE:   if (w_fall && !w_data_s) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_fall) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_stop_done = 1'b1;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && !w_fall && r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      w_state_nxt = ST_IDLE;
      w_timeout   = 1'b1;
    end
  end

  // Shift/parity capture, timeout counter, prefix flags and pending event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_par      <= 1'b0;
      r_to_cnt   <= '0;
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
      r_new_vld  <= 1'b0;
      r_new_evt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_new_vld <= 1'b0;
      if (w_fall) begin
        case (r_state)
          ST_IDLE:   r_bit_cnt <= 3'd0;
          ST_DATA: begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_PARITY: r_par <= w_data_s;
          default:   ;
        endcase
      end
      if (r_state == ST_IDLE || w_fall) r_to_cnt <= '0;
      else                              r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_timeout) begin
        r_err      <= 1'b1;
        r_ext_flag <= 1'b0;
        r_brk_flag <= 1'b0;
      end
      if (w_stop_done) begin
        if (!w_good) begin
          r_err      <= 1'b1;
          r_ext_flag <= 1'b0;
          r_brk_flag <= 1'b0;
        end else if (r_shift == PS2_EXT) begin
          r_ext_flag <= 1'b1;
        end else if (r_shift == PS2_BRK) begin
          r_brk_flag <= 1'b1;
        end else begin
          r_new_vld      <= 1'b1;
          r_new_evt.code <= r_shift;
          r_new_evt.rel  <= r_brk_flag;
          r_new_evt.ext  <= r_ext_flag;
          r_ext_flag     <= 1'b0;
          r_brk_flag     <= 1'b0;
        end
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_evt <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_new_vld) begin
        if (!r_valid || ready_i) begin
          r_out_evt <= r_new_evt;
          r_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign code_o     = r_out_evt.code;
  assign release_o  = r_out_evt.rel;
  assign extended_o = r_out_evt.ext;
  assign valid_o    = r_valid;
  assign err_o      = r_err;
  assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Self-checking bench for ps2_kb_rx: directed frame table, corner sequences, random frames vs model.
module tb_ps2_kb_rx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 300;
  localparam int          HALF = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] code_o;
  logic       release_o;
  logic       extended_o;
  logic       valid_o;
  logic       err_o;
  logic       overrun_o;

  ps2_kb_rx #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .code_o    (code_o),
    .release_o (release_o),
    .extended_o(extended_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .err_o     (err_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    bit         bad;
    bit         ev;
    logic [7:0] code;
    bit         rel;
    bit         ext;
    bit         err;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   last_valid_rise = -1;
  int   err_cnt = 0;
  int   ovr_cnt = 0;
  logic prev_valid = 1'b0;
  ev_t  got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe accepted events and pulse outputs away from the active edge.
  always @(negedge clk) begin
    if (valid_o && ready_i) got_q.push_back({code_o, release_o, extended_o});
    if (err_o) err_cnt++;
    if (overrun_o) ovr_cnt++;
    if (valid_o && !prev_valid) last_valid_rise = cyc;
    prev_valid = valid_o;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive the first nbits of an 11-bit frame; parity inverted when bad.
  task automatic send_frame(input logic [7:0] d, input bit bad, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = ~(^d) ^ bad;
    fr  = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data_i = fr[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk_i = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk_i = 1'b1;
    end
    repeat (2 * HALF) @(posedge clk);
    #1 ps2_data_i = 1'b1;
  endtask

  vec_t vt[$];
  ev_t  exp_q[$];
  int   n_got;
  int   n_err;
  int   n_ovr;
  int   exp_err;
  bit   m_ext;
  bit   m_brk;
  ev_t  e;

  initial begin
    // Reset state.
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_code", 32'(code_o), 32'd0);
    chk("rst_rel", 32'(release_o), 32'd0);
    chk("rst_ext", 32'(extended_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Directed frame table.
    vt.push_back('{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0});
    vt.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0});
    vt.push_back('{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vt.push_back('{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vt.push_back('{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < vt.size(); i++) begin
      n_got = got_q.size();
      n_err = err_cnt;
      send_frame(vt[i].d, vt[i].bad, 11);
      chk($sformatf("tbl%0d_evcnt", i), 32'(got_q.size() - n_got), 32'(vt[i].ev));
      chk($sformatf("tbl%0d_err", i), 32'(err_cnt - n_err), 32'(vt[i].err));
      if (vt[i].ev && got_q.size() > n_got) begin
        e = got_q[got_q.size() - 1];
        chk($sformatf("tbl%0d_code", i), 32'(e.code), 32'(vt[i].code));
        chk($sformatf("tbl%0d_rel", i), 32'(e.rel), 32'(vt[i].rel));
        chk($sformatf("tbl%0d_ext", i), 32'(e.ext), 32'(vt[i].ext));
      end
      if (i == 0) chk("latency", 32'(last_valid_rise - last_fall_cyc), 32'(SYNC + 2));
    end

    // Glitch in idle with data high is ignored, no timeout follows.
    n_err = err_cnt;
    n_got = got_q.size();
    @(posedge clk); #1 ps2_data_i = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_i = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_i = 1'b1;
    repeat (TO + 50) @(posedge clk);
    chk("glitch_err", 32'(err_cnt - n_err), 32'd0);
    chk("glitch_ev", 32'(got_q.size() - n_got), 32'd0);

    // Partial frame times out, then a full frame decodes.
    send_frame(8'h29, 1'b0, 5);
    repeat (TO + 50) @(posedge clk);
    chk("to_err", 32'(err_cnt - n_err), 32'd1);
    chk("to_ev", 32'(got_q.size() - n_got), 32'd0);
    send_frame(8'h29, 1'b0, 11);
    chk("to_next_evcnt", 32'(got_q.size() - n_got), 32'd1);
    if (got_q.size() > n_got) chk("to_next_code", 32'(got_q[got_q.size() - 1].code), 32'h29);

    // Overrun while consumer stalls.
    n_err = err_cnt;
    n_ovr = ovr_cnt;
    @(posedge clk); #1 ready_i = 1'b0;
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'h32, 1'b0, 11);
    chk("ovr_valid", 32'(valid_o), 32'd1);
    chk("ovr_code", 32'(code_o), 32'h1C);
    chk("ovr_pulse", 32'(ovr_cnt - n_ovr), 32'd1);
    chk("ovr_err", 32'(err_cnt - n_err), 32'd0);
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("ovr_drop", 32'(valid_o), 32'd0);
    chk("ovr_accept", 32'(got_q[got_q.size() - 1].code), 32'h1C);

    // Reset mid-frame with a held event and a pending E0 prefix.
    ready_i = 1'b0;
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h29, 1'b0, 4);
    n_err = err_cnt;
    n_ovr = ovr_cnt;
    #3 reset = 1'b1;
    #1;
    chk("rstmid_valid", 32'(valid_o), 32'd0);
    chk("rstmid_code", 32'(code_o), 32'd0);
    chk("rstmid_err", 32'(err_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ready_i = 1'b1;
    repeat (TO + 50) @(posedge clk);
    chk("rstmid_noerr", 32'(err_cnt - n_err), 32'd0);
    n_got = got_q.size();
    send_frame(8'h1C, 1'b0, 11);
    chk("rstmid_evcnt", 32'(got_q.size() - n_got), 32'd1);
    if (got_q.size() > n_got) begin
      e = got_q[got_q.size() - 1];
      chk("rstmid_code2", 32'(e.code), 32'h1C);
      chk("rstmid_ext", 32'(e.ext), 32'd0);
    end

    // Random frames against a prefix-folding reference model.
    n_got   = got_q.size();
    n_err   = err_cnt;
    exp_err = 0;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int   r;
      logic [7:0] d;
      bit   bad;
      r   = int'($urandom_range(0, 9));
      d   = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 9) == 0);
      if (bad) begin
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (d == 8'hE0) begin
        m_ext = 1'b1;
      end else if (d == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        exp_q.push_back({d, m_brk, m_ext});
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      send_frame(d, bad, 11);
    end
    chk("rnd_evcnt", 32'(got_q.size() - n_got), 32'(exp_q.size()));
    chk("rnd_err", 32'(err_cnt - n_err), 32'(exp_err));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (n_got + i < got_q.size())
        chk($sformatf("rnd_ev%0d", i), 32'(got_q[n_got + i]), 32'(exp_q[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_kb_rx.md
Name: ps2_kb_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the keyboard register peripheral. It synchronises the raw PS/2 clock and data pins and deframes 11-bit PS/2 frames. It folds the E0 (extended) and F0 (break) prefixes into flags and presents one decoded key event at a time on a valid/ready interface. The keyboard peripheral consumes each event, latches it and raises its interrupt.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the pin synchronisers (minimum 2).
TIMEOUT_CYCLES, 2000, clk cycles without a PS/2 falling edge after which a partial frame is aborted (200 us at 10 MHz).

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  asynchronous, active-high reset.
ps2_clk_i  input  1  raw PS/2 clock pin, asynchronous to clk.
ps2_data_i  input  1  raw PS/2 data pin, asynchronous to clk.
code_o  output  8  scan code of the event (prefixes stripped).
release_o  output  1  1 = break (key released), 0 = make.
extended_o  output  1  1 = code was preceded by E0.
valid_o  output  1  event on code_o/release_o/extended_o is valid.
ready_i  input  1  consumer accepts the event when valid_o && ready_i.
err_o  output  1  one-cycle pulse on a frame error (start, parity, stop or timeout).
overrun_o  output  1  one-cycle pulse when a decoded event is dropped.

Behaviour:
- Reset (async assert, sync deassert by clk domain):
  - all outputs 0; FSM to IDLE; prefix flags, bit counter and timeout counter cleared.
  - Synchronisers reset to 1 (idle bus level).
  - Reset mid-frame discards the partial frame silently; err_o is not pulsed.
- Sync/edge detect:
  - Each pin passes SYNC_STAGES flops.
  - fall = synced ps2_clk previous 1, current 0.
  - Data is sampled from the synced data on the fall cycle only.
- FSM, advancing on fall only:
  - IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay IDLE, glitch ignored, no error.
  - DATA: shift LSB first into an 8-bit shift register; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: frame is good if the data+parity ones-count is odd and the stop bit is 1. Always return to IDLE.
  - Bad frame: err_o pulse on the cycle after the STOP sample, byte discarded, both prefix flags cleared.
- Timeout:
  - The counter runs while the FSM is not IDLE and clears on every fall.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, err_o pulse, prefix flags cleared.
- Prefix decode (good byte):
  - 8'hE0 sets ext_flag; 8'hF0 sets brk_flag; no event is emitted for either.
  - Any other byte emits an event {code, brk_flag, ext_flag}, then clears both flags.
- Output register:
  - An event is emitted one clk after the STOP-sampling fall.
  - Total latency from the pin edge is SYNC_STAGES+2 cycles.
  - If valid_o=0, or valid_o && ready_i in the same cycle, load the event and set valid_o=1.
  - If valid_o && !ready_i: hold the existing event, drop the new one, pulse overrun_o.
  - valid_o && ready_i with no new event: valid_o <= 0 next cycle.
  - Outputs are stable while valid_o && !ready_i.
- err_o and overrun_o are mutually exclusive per frame. Neither affects valid_o.

Decomposition:
- Shared package kb_pkg:
  - FSM state encoding (IDLE, DATA, PARITY, STOP, 2 bits).
  - Constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0.
  - Typedef for the event bundle {code[7:0], release, extended}.
- One sub-module, ps2_sync: pin synchroniser plus falling-edge detector for ps2_clk, and synchroniser for ps2_data. Parameter SYNC_STAGES; outputs data_s and fall.
- FSM, prefix decode and output register live in ps2_kb_rx.

Test Plan:
1. Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1), ready_i=1 -> valid_o pulse, code_o=8'h1C, release_o=0, extended_o=0, err_o stays 0.
2. Frames F0 then 1C -> exactly one event: code_o=8'h1C, release_o=1, extended_o=0; no event for F0.
3. Frames E0, F0, 75 -> one event: code_o=8'h75, extended_o=1, release_o=1. A following frame 1C -> extended_o=0, release_o=0.
4. Frame 0x1C with parity bit 1 -> err_o one-cycle pulse, no valid_o. A following correct 0x1C decodes normally.
5. Five bits then an idle line for TIMEOUT_CYCLES -> err_o pulse, FSM back to IDLE. The next full 0x29 frame yields code_o=8'h29.
6. ready_i=0; frames 1C then 32 -> valid_o held with code_o=8'h1C, overrun_o pulse on the 32 event. Then ready_i=1 -> valid_o drops. Assert reset mid-frame -> all outputs 0 immediately and no err_o.
